fifo_rd_adapter: RTL and testbench

FIFO_RD_ADAPTER -- requirements
Module: fifo_rd_adapter

---
 rtl/fifo_rd_adapter_if.sv | 27 ++
 rtl/fifo_rd_adapter.sv | 99 +++++++++
 tb/tb_fifo_rd_adapter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_adapter_if.sv
// Bundle of the upstream FIFO read port and the downstream valid/ready stream
// handled by fifo_rd_adapter, plus its occupancy/pop counters.
interface fifo_rd_adapter_if #(
   parameter int width = 16,
   parameter int depth = 16
);
   localparam int cnt_w = $clog2(depth) + 1;

   logic             fifo_empty;
   logic [width-1:0] fifo_data_out;
   logic             fifo_read;
   logic             m_valid;
   logic [width-1:0] m_data;
   logic             m_ready;
   logic [1:0]       buf_cnt;
   logic [cnt_w-1:0] pop_cnt;

   modport master (
      input  fifo_empty, fifo_data_out, m_ready,
      output fifo_read, m_valid, m_data, buf_cnt, pop_cnt
   );

   modport slave (
      output fifo_empty, fifo_data_out, m_ready,
      input  fifo_read, m_valid, m_data, buf_cnt, pop_cnt
   );
endinterface

// File: rtl/fifo_rd_adapter.sv
// Turns a 1-cycle-latency FIFO read port into a valid/ready stream through a
// 2-entry buffer; pops are issued only against guaranteed buffer space.
module fifo_rd_adapter #(
   parameter int width = 16,
   parameter int depth = 16
) (
   input  logic               clk,
   input  logic               rst,
   fifo_rd_adapter_if.master  bus
);
   localparam int cnt_w = $clog2(depth) + 1;

   logic [width-1:0] head_r;
   logic [width-1:0] tail_r;
   logic [1:0]       cnt_r;
   logic             valid_r;
   logic             inflight_r;
   logic [cnt_w-1:0] pop_cnt_r;

   logic [width-1:0] head_nxt_s;
   logic [width-1:0] tail_nxt_s;
   logic [1:0]       cnt_nxt_s;
   logic             xfer_s;
   logic [2:0]       occ_s;
   logic             rd_s;

   // Credit check: a transfer implies cnt_r >= 1, so occ_s cannot underflow
   always_comb begin
      xfer_s = valid_r & bus.m_ready;
      occ_s  = {1'b0, cnt_r} + {2'b00, inflight_r} - {2'b00, xfer_s};
      if (!rst && !bus.fifo_empty && (occ_s < 3'd2)) begin
         rd_s = 1'b1;
      end else begin
         rd_s = 1'b0;
      end
   end

   // Buffer next state: capture lands in the first free slot, transfer shifts tail to head
   always_comb begin
      head_nxt_s = head_r;
      tail_nxt_s = tail_r;
      cnt_nxt_s  = cnt_r;
      case ({inflight_r, xfer_s})
         2'b10: begin
            if (cnt_r == 2'd0) begin
               head_nxt_s = bus.fifo_data_out;
               cnt_nxt_s  = 2'd1;
            end else begin
               tail_nxt_s = bus.fifo_data_out;
               cnt_nxt_s  = 2'd2;
            end
         end
         2'b01: begin
            head_nxt_s = tail_r;
            cnt_nxt_s  = cnt_r - 2'd1;
         end
         2'b11: begin
            if (cnt_r == 2'd1) begin
               head_nxt_s = bus.fifo_data_out;
            end else begin
               head_nxt_s = tail_r;
               tail_nxt_s = bus.fifo_data_out;
            end
         end
         default: begin
            cnt_nxt_s = cnt_r;
         end
      endcase
   end

   // State registers; clearing inflight_r on reset drops any read data still in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         head_r     <= {width{1'b0}};
         tail_r     <= {width{1'b0}};
         cnt_r      <= 2'd0;
         valid_r    <= 1'b0;
         inflight_r <= 1'b0;
         pop_cnt_r  <= {cnt_w{1'b0}};
      end else begin
         head_r     <= head_nxt_s;
         tail_r     <= tail_nxt_s;
         cnt_r      <= cnt_nxt_s;
         valid_r    <= (cnt_nxt_s != 2'd0);
         inflight_r <= rd_s;
         if (rd_s) begin
            pop_cnt_r <= pop_cnt_r + {{(cnt_w-1){1'b0}}, 1'b1};
         end else begin
            pop_cnt_r <= pop_cnt_r;
         end
      end
   end

   assign bus.fifo_read = rd_s;
   assign bus.m_valid   = valid_r;
   assign bus.m_data    = head_r;
   assign bus.buf_cnt   = cnt_r;
   assign bus.pop_cnt   = pop_cnt_r;
endmodule

// File: tb/tb_fifo_rd_adapter.sv
// Directed bench for fifo_rd_adapter: a cycle-by-cycle vector table plus
// streaming, empty, and backpressure runs against a small FIFO model.
module tb_fifo_rd_adapter;
   logic clk;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   fifo_rd_adapter_if #(.width(16), .depth(16)) bus ();

   fifo_rd_adapter #(.width(16), .depth(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Upstream source: either the table drives the FIFO pins or the FIFO model does
   logic        use_model;
   logic        tab_empty;
   logic [15:0] tab_din;
   logic        mdl_clr;
   logic [15:0] mem [0:31];
   int          rd_ptr;
   int          wr_ptr;
   logic [15:0] mdl_dout;

   always @(posedge clk) begin
      if (mdl_clr) begin
         rd_ptr   <= 0;
         mdl_dout <= 16'h0000;
      end else if (use_model && bus.fifo_read) begin
         mdl_dout <= mem[rd_ptr[4:0]];
         rd_ptr   <= rd_ptr + 1;
      end
   end

   assign bus.fifo_empty    = use_model ? (rd_ptr == wr_ptr) : tab_empty;
   assign bus.fifo_data_out = use_model ? mdl_dout : tab_din;

   typedef struct {
      logic        rst;
      logic        empty;
      logic        rdy;
      logic [15:0] din;
      logic        exp_rd;
      logic        exp_v;
      logic [1:0]  exp_cnt;
      logic [4:0]  exp_pop;
      logic        chk_d;
      logic [15:0] exp_d;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic r, input logic e, input logic rdy, input logic [15:0] din,
                      input logic rd, input logic v, input logic [1:0] cnt, input logic [4:0] pop,
                      input logic cd, input logic [15:0] d);
      vec_t x;
      x.rst = r; x.empty = e; x.rdy = rdy; x.din = din;
      x.exp_rd = rd; x.exp_v = v; x.exp_cnt = cnt; x.exp_pop = pop;
      x.chk_d = cd; x.exp_d = d;
      vq.push_back(x);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic model_reset(input int n);
      @(negedge clk);
      use_model = 1'b1;
      mdl_clr   = 1'b1;
      rst       = 1'b1;
      bus.m_ready = 1'b0;
      wr_ptr    = 0;
      @(posedge clk);
      @(negedge clk);
      wr_ptr    = n;
      mdl_clr   = 1'b0;
      rst       = 1'b0;
   endtask

   initial begin
      int got;
      int first;
      int viol;
      int moves;
      logic [15:0] held;

      use_model = 1'b0;
      mdl_clr   = 1'b1;
      tab_empty = 1'b1;
      tab_din   = 16'h0000;
      rst       = 1'b1;
      bus.m_ready = 1'b0;
      wr_ptr    = 0;

      //   rst  emp  rdy  din       rd   v    cnt   pop    chk  data
      add(1'b1,1'b0,1'b0,16'h0000, 1'b0,1'b0,2'd0,5'd0, 1'b1,16'h0000);
      add(1'b1,1'b0,1'b0,16'h0000, 1'b0,1'b0,2'd0,5'd0, 1'b1,16'h0000);
      add(1'b0,1'b0,1'b0,16'h0000, 1'b1,1'b0,2'd0,5'd1, 1'b0,16'h0000);
      add(1'b0,1'b0,1'b0,16'h00A1, 1'b1,1'b1,2'd1,5'd2, 1'b1,16'h00A1);
      add(1'b0,1'b0,1'b0,16'h00B2, 1'b0,1'b1,2'd2,5'd2, 1'b1,16'h00A1);
      add(1'b0,1'b0,1'b0,16'hDEAD, 1'b0,1'b1,2'd2,5'd2, 1'b1,16'h00A1);
      add(1'b0,1'b0,1'b1,16'hDEAD, 1'b1,1'b1,2'd1,5'd3, 1'b1,16'h00B2);
      add(1'b0,1'b0,1'b1,16'h00C3, 1'b1,1'b1,2'd1,5'd4, 1'b1,16'h00C3);
      add(1'b0,1'b1,1'b0,16'h00D4, 1'b0,1'b1,2'd2,5'd4, 1'b1,16'h00C3);
      add(1'b0,1'b1,1'b1,16'h0000, 1'b0,1'b1,2'd1,5'd4, 1'b1,16'h00D4);
      add(1'b0,1'b1,1'b1,16'h0000, 1'b0,1'b0,2'd0,5'd4, 1'b0,16'h0000);
      add(1'b0,1'b1,1'b1,16'h0000, 1'b0,1'b0,2'd0,5'd4, 1'b0,16'h0000);
      add(1'b0,1'b0,1'b0,16'h0000, 1'b1,1'b0,2'd0,5'd5, 1'b0,16'h0000);
      add(1'b0,1'b0,1'b0,16'h00E5, 1'b1,1'b1,2'd1,5'd6, 1'b1,16'h00E5);
      add(1'b1,1'b0,1'b0,16'h00F6, 1'b0,1'b0,2'd0,5'd0, 1'b1,16'h0000);
      add(1'b0,1'b1,1'b0,16'h00F6, 1'b0,1'b0,2'd0,5'd0, 1'b0,16'h0000);
      add(1'b0,1'b0,1'b1,16'h0000, 1'b1,1'b0,2'd0,5'd1, 1'b0,16'h0000);
      add(1'b0,1'b0,1'b1,16'h1234, 1'b1,1'b1,2'd1,5'd2, 1'b1,16'h1234);

      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clk);
         rst         = vq[i].rst;
         tab_empty   = vq[i].empty;
         bus.m_ready = vq[i].rdy;
         tab_din     = vq[i].din;
         #1;
         chk($sformatf("r%0d_fifo_read", i), 32'(bus.fifo_read), 32'(vq[i].exp_rd));
         @(posedge clk);
         #1;
         chk($sformatf("r%0d_m_valid", i), 32'(bus.m_valid), 32'(vq[i].exp_v));
         chk($sformatf("r%0d_buf_cnt", i), 32'(bus.buf_cnt), 32'(vq[i].exp_cnt));
         chk($sformatf("r%0d_pop_cnt", i), 32'(bus.pop_cnt), 32'(vq[i].exp_pop));
         if (vq[i].chk_d) begin
            chk($sformatf("r%0d_m_data", i), 32'(bus.m_data), 32'(vq[i].exp_d));
         end
      end

      // Streaming: 16 preloaded words, one beat per cycle in pop order
      for (int k = 0; k < 16; k++) mem[k] = 16'(k + 1);
      model_reset(16);
      bus.m_ready = 1'b1;
      got = 0; first = -1; viol = 0;
      for (int cyc = 0; cyc < 60 && got < 16; cyc++) begin
         #1;
         if (bus.fifo_read && bus.fifo_empty) viol++;
         if (bus.m_valid && bus.m_ready) begin
            chk($sformatf("stream_data%0d", got), 32'(bus.m_data), 32'(got + 1));
            if (first < 0) first = cyc;
            else chk($sformatf("stream_gap%0d", got), 32'(cyc - first), 32'(got));
            got++;
         end
         @(negedge clk);
      end
      chk("stream_beats", 32'(got), 32'd16);
      // Empty: FIFO stays empty for 10 cycles after the buffer drains
      for (int cyc = 0; cyc < 10; cyc++) begin
         #1;
         if (bus.fifo_read && bus.fifo_empty) viol++;
         if (cyc >= 2) begin
            chk($sformatf("empty_read%0d", cyc), 32'(bus.fifo_read), 32'd0);
            chk($sformatf("empty_valid%0d", cyc), 32'(bus.m_valid), 32'd0);
         end
         @(negedge clk);
      end
      chk("stream_pop_cnt", 32'(bus.pop_cnt), 32'd16);
      chk("read_while_empty", 32'(viol), 32'd0);

      // Backpressure: only two pops while stalled, head held, order kept on release
      for (int k = 0; k < 5; k++) mem[k] = 16'(16'h0101 * (k + 1));
      model_reset(5);
      bus.m_ready = 1'b0;
      moves = 0; held = 16'h0000;
      for (int cyc = 0; cyc < 8; cyc++) begin
         #1;
         if (bus.m_valid) begin
            if (cyc > 0 && held !== bus.m_data) moves++;
            held = bus.m_data;
         end
         @(negedge clk);
      end
      #1;
      chk("bp_pop_cnt", 32'(bus.pop_cnt), 32'd2);
      chk("bp_buf_cnt", 32'(bus.buf_cnt), 32'd2);
      chk("bp_head", 32'(bus.m_data), 32'h0101);
      chk("bp_data_moves", 32'(moves), 32'd1);
      @(negedge clk);
      bus.m_ready = 1'b1;
      got = 0;
      for (int cyc = 0; cyc < 30 && got < 5; cyc++) begin
         #1;
         if (bus.m_valid && bus.m_ready) begin
            chk($sformatf("bp_data%0d", got), 32'(bus.m_data), 32'(16'h0101 * (got + 1)));
            got++;
         end
         @(negedge clk);
      end
      chk("bp_beats", 32'(got), 32'd5);
      chk("bp_final_pop_cnt", 32'(bus.pop_cnt), 32'd5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
